// File: rtl/costas_loop_filter.sv
// rtl/costas_loop_filter.sv - BPSK Costas loop phase detector and PI loop filter
//
// Purpose: forms the phase error I*Q from matched-filtered arm samples and
// runs it through a shift-gain proportional-integral filter. The result is
// the signed frequency-correction word for the NCO stage. Also provides an
// integrator freeze and a lock indicator.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   KP_SHIFT          proportional gain (arithmetic right shift of err)
//   KI_SHIFT          integral gain (arithmetic right shift of scaled err)
//   freeze            holds the integrator while 1
//   i_tdata, q_tdata  signed I/Q arm samples
//   iq_tvalid         sample valid, no backpressure
//   feedback_tdata    signed correction word
//   feedback_tvalid   one-cycle pulse per sample, iq_tvalid delayed 3 cycles
//   locked            set after LOCK_COUNT consecutive small-error samples

module costas_loop_filter #(
  parameter int WIDTH       = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int LOCK_THRESH = 1024,
  parameter int LOCK_COUNT  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              KP_SHIFT,
  input  logic [3:0]              KI_SHIFT,
  input  logic                    freeze,
  input  logic signed [WIDTH-1:0] i_tdata,
  input  logic signed [WIDTH-1:0] q_tdata,
  input  logic                    iq_tvalid,
  output logic signed [WIDTH-1:0] feedback_tdata,
  output logic                    feedback_tvalid,
  output logic                    locked
);

  localparam int SHIFT = ACC_WIDTH - WIDTH;
  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  localparam logic signed [WIDTH-1:0]     W_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]     W_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]              THRESH  = LOCK_THRESH[WIDTH:0];
  localparam logic [CNT_W-1:0]            CNT_MAX = LOCK_COUNT[CNT_W-1:0];

  // Pipeline registers
  logic                    v1, v2, v3;
  logic signed [WIDTH-1:0] err1;
  logic signed [WIDTH-1:0] prop2;
  logic signed [ACC_WIDTH-1:0] integ;
  logic [CNT_W-1:0]        cnt;

  // Stage 1: phase error
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH:0]     err_wide;
  logic signed [WIDTH-1:0]   err_sat;
  logic                      unused_prod_lsbs;

  always_comb begin
    prod = i_tdata * q_tdata;
    // Arithmetic shift by WIDTH-1 keeps WIDTH+1 significant bits; only
    // (-max)*(-max) can exceed the WIDTH-bit range.
    err_wide = prod[2*WIDTH-1:WIDTH-1];
    if (err_wide[WIDTH] != err_wide[WIDTH-1])
      err_sat = err_wide[WIDTH] ? W_MIN : W_MAX;
    else
      err_sat = err_wide[WIDTH-1:0];
  end

  assign unused_prod_lsbs = ^prod[WIDTH-2:0];

  // Stage 2: proportional term, integrator, lock counter
  logic signed [WIDTH-1:0]     prop_next;
  logic signed [ACC_WIDTH-1:0] inc_base;
  logic signed [ACC_WIDTH-1:0] inc;
  logic signed [ACC_WIDTH:0]   integ_sum;
  logic signed [ACC_WIDTH-1:0] integ_next;
  logic signed [WIDTH:0]       err_ext;
  logic [WIDTH:0]              err_abs;
  logic [CNT_W-1:0]            cnt_next;

  always_comb begin
    prop_next = err1 >>> KP_SHIFT;
    inc_base  = {err1, {SHIFT{1'b0}}};
    inc       = inc_base >>> KI_SHIFT;
    integ_sum = {integ[ACC_WIDTH-1], integ} + {inc[ACC_WIDTH-1], inc};
    if (integ_sum[ACC_WIDTH] != integ_sum[ACC_WIDTH-1])
      integ_next = integ_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else
      integ_next = integ_sum[ACC_WIDTH-1:0];

    // One extra bit so that |-2^(WIDTH-1)| is representable
    err_ext = {err1[WIDTH-1], err1};
    err_abs = err_ext[WIDTH] ? (-err_ext) : err_ext;
    if (err_abs < THRESH)
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    else
      cnt_next = '0;
  end

  // Stage 3: output sum using the integrator already updated by this sample
  logic signed [WIDTH-1:0] integ_hi;
  logic signed [WIDTH:0]   out_sum;
  logic signed [WIDTH-1:0] out_sat;

  always_comb begin
    integ_hi = integ[ACC_WIDTH-1:SHIFT];
    out_sum  = {prop2[WIDTH-1], prop2} + {integ_hi[WIDTH-1], integ_hi};
    if (out_sum[WIDTH] != out_sum[WIDTH-1])
      out_sat = out_sum[WIDTH] ? W_MIN : W_MAX;
    else
      out_sat = out_sum[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1             <= 1'b0;
      v2             <= 1'b0;
      v3             <= 1'b0;
      err1           <= '0;
      prop2          <= '0;
      integ          <= '0;
      cnt            <= '0;
      locked         <= 1'b0;
      feedback_tdata <= '0;
    end else begin
      v1 <= iq_tvalid;
      if (iq_tvalid)
        err1 <= err_sat;

      v2 <= v1;
      if (v1) begin
        prop2 <= prop_next;
        if (!freeze)
          integ <= integ_next;
        cnt    <= cnt_next;
        locked <= (cnt_next == CNT_MAX);
      end

      v3 <= v2;
      if (v2)
        feedback_tdata <= out_sat;
    end
  end

  assign feedback_tvalid = v3;

endmodule

// File: tb/tb_costas_loop_filter.sv
// tb/tb_costas_loop_filter.sv - scoreboard bench for costas_loop_filter

module tb_costas_loop_filter;

  logic               clk;
  logic               rst;
  logic [3:0]         kp_shift;
  logic [3:0]         ki_shift;
  logic               freeze;
  logic signed [15:0] i_tdata;
  logic signed [15:0] q_tdata;
  logic               iq_tvalid;
  logic signed [15:0] feedback_tdata;
  logic               feedback_tvalid;
  logic               locked;

  costas_loop_filter dut (
    .clk             (clk),
    .rst             (rst),
    .KP_SHIFT        (kp_shift),
    .KI_SHIFT        (ki_shift),
    .freeze          (freeze),
    .i_tdata         (i_tdata),
    .q_tdata         (q_tdata),
    .iq_tvalid       (iq_tvalid),
    .feedback_tdata  (feedback_tdata),
    .feedback_tvalid (feedback_tvalid),
    .locked          (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  longint fb_q[$];
  longint lk_q[$];
  longint m_integ = 0;
  longint m_cnt   = 0;
  logic [2:0] hist = 3'b000;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Drive one sample and push the reference results for it
  task automatic send(input int i, input int q);
    longint p, err, prop, inc, aerr;
    @(negedge clk);
    i_tdata   = 16'(i);
    q_tdata   = 16'(q);
    iq_tvalid = 1'b1;
    p    = longint'(i) * longint'(q);
    err  = clamp(p >>> 15, -32768, 32767);
    prop = err >>> kp_shift;
    inc  = (err * 256) >>> ki_shift;
    if (!freeze)
      m_integ = clamp(m_integ + inc, -8388608, 8388607);
    fb_q.push_back(clamp(prop + (m_integ >>> 8), -32768, 32767));
    aerr = (err < 0) ? -err : err;
    if (aerr < 1024)
      m_cnt = (m_cnt == 256) ? 256 : m_cnt + 1;
    else
      m_cnt = 0;
    lk_q.push_back((m_cnt == 256) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      iq_tvalid = 1'b0;
    end
  endtask

  // Monitor: hist[1] marks a stage-2 update at this edge, hist[2] an output
  always @(posedge clk) begin
    logic r;
    longint e;
    r = rst;
    if (r) begin
      hist = 3'b000;
      fb_q.delete();
      lk_q.delete();
    end else begin
      hist = {hist[1:0], iq_tvalid};
    end
    #1;
    check("fb_tvalid", longint'(feedback_tvalid), longint'(hist[2]));
    if (r) begin
      check("rst_fb_tdata", longint'(feedback_tdata), 0);
      check("rst_locked", longint'(locked), 0);
    end
    if (hist[2]) begin
      if (fb_q.size() == 0) check("fb_q_underflow", 1, 0);
      else begin
        e = fb_q.pop_front();
        check("fb_tdata", longint'(feedback_tdata), e);
      end
    end
    if (hist[1]) begin
      if (lk_q.size() == 0) check("lk_q_underflow", 1, 0);
      else begin
        e = lk_q.pop_front();
        check("locked", longint'(locked), e);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    kp_shift  = 4'd2;
    ki_shift  = 4'd4;
    freeze    = 1'b0;
    i_tdata   = 16'sd16384;
    q_tdata   = 16'sd8192;
    iq_tvalid = 1'b1;

    // Reset held 3 cycles with valid input
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    iq_tvalid = 1'b0;
    m_integ   = 0;
    m_cnt     = 0;

    // Basic response: 1280 then 1536
    send(16384, 8192);
    idle(4);
    send(16384, 8192);
    idle(4);

    // Freeze holds the integrator, release continues to 1792
    freeze = 1'b1;
    for (int k = 0; k < 10; k++) send(16384, 8192);
    idle(4);
    freeze = 1'b0;
    send(16384, 8192);
    idle(4);

    // Saturation of error, integrator and output
    kp_shift = 4'd0;
    ki_shift = 4'd0;
    send(-32768, -32768);
    send(-32768, -32768);
    for (int k = 0; k < 4; k++) send(32767, -32768);
    idle(4);

    // Lock acquisition with gaps, then one bad sample
    kp_shift = 4'd2;
    ki_shift = 4'd4;
    for (int k = 0; k < 256; k++) begin
      send(1024, 1024);
      if (k % 37 == 5) idle(2);
    end
    send(16384, 8192);
    send(1024, 1024);
    send(1024, 1024);
    idle(4);

    // Reset mid-stream
    send(16384, 8192);
    send(16384, 8192);
    @(negedge clk);
    rst       = 1'b1;
    i_tdata   = 16'sd16384;
    q_tdata   = 16'sd8192;
    iq_tvalid = 1'b1;
    m_integ   = 0;
    m_cnt     = 0;
    @(negedge clk);
    rst       = 1'b0;
    iq_tvalid = 1'b0;
    send(16384, 8192);
    send(16384, 8192);
    idle(6);

    check("fb_q_drained", longint'(fb_q.size()), 0);
    check("lk_q_drained", longint'(lk_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
